// File: rtl/text_ram_writer.sv
`default_nettype none
// ============================================================================
// Module      : text_ram_writer
// Description : Write-port controller for the character text RAM. Accepts
//               ASCII bytes over valid/ready, tracks a wrapping cursor,
//               turns glyph bytes into single RAM writes, interprets
//               CR/LF/BS/FF, and runs a clear-screen fill with spaces.
// Revision    : 1.0 - initial release
// ============================================================================
module text_ram_writer #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            char_in,
    input  logic                  char_valid,
    output logic                  char_ready,
    input  logic                  clear_req,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  write_en,
    output logic [6:0]            cursor_col,
    output logic [4:0]            cursor_row,
    output logic                  busy
);

    localparam int                  TOTAL     = COLS * ROWS;
    localparam logic [6:0]          LAST_COL  = 7'(COLS - 1);
    localparam logic [4:0]          LAST_ROW  = 5'(ROWS - 1);
    localparam logic [ADDR_WIDTH-1:0] COLS_A  = ADDR_WIDTH'(COLS);
    // Counter is one bit wider so it can reach TOTAL as the exit marker
    localparam logic [ADDR_WIDTH:0] CLR_TOTAL = (ADDR_WIDTH + 1)'(TOTAL);
    localparam logic [DATA_WIDTH-1:0] SPACE   = DATA_WIDTH'(8'h20);

    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_FF = 8'h0C;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_DEL = 8'h7F;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [ADDR_WIDTH:0]   clr_cnt;

    logic                  accept;
    logic                  is_glyph;
    logic                  row_wrap;
    logic [4:0]            row_next;
    logic [ADDR_WIDTH-1:0] row_base_next;
    logic [ADDR_WIDTH-1:0] cur_addr;

    // A pending clear takes priority over a waiting character
    assign char_ready    = (state == IDLE) && !clear_req;
    assign accept        = char_valid && char_ready;
    // 0x20..0x7E and 0x80..0xFF are drawn; DEL and C0 codes are not
    assign is_glyph      = (char_in >= 8'h20) && (char_in != CH_DEL);
    assign row_wrap      = (cursor_row == LAST_ROW);
    assign row_next      = row_wrap ? 5'd0 : cursor_row + 5'd1;
    assign row_base_next = row_wrap ? '0 : row_base + COLS_A;
    assign cur_addr      = row_base + ADDR_WIDTH'(cursor_col);

    // Controller FSM: cursor tracking, glyph writes and clear-screen fill
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            waddr      <= '0;
            wdata      <= '0;
            write_en   <= 1'b0;
            busy       <= 1'b0;
            cursor_col <= 7'd0;
            cursor_row <= 5'd0;
            row_base   <= '0;
            clr_cnt    <= '0;
        end else begin
            write_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req || (accept && char_in == CH_FF)) begin
                        // First fill write goes out with busy, so busy and
                        // the write strobes cover exactly the same cycles
                        state    <= CLEAR;
                        busy     <= 1'b1;
                        write_en <= 1'b1;
                        waddr    <= '0;
                        wdata    <= SPACE;
                        clr_cnt  <= (ADDR_WIDTH + 1)'(1);
                    end else if (accept) begin
                        if (is_glyph) begin
                            write_en <= 1'b1;
                            wdata    <= DATA_WIDTH'(char_in);
                            waddr    <= cur_addr;
                            if (cursor_col == LAST_COL) begin
                                cursor_col <= 7'd0;
                                cursor_row <= row_next;
                                row_base   <= row_base_next;
                            end else begin
                                cursor_col <= cursor_col + 7'd1;
                            end
                        end else if (char_in == CH_CR) begin
                            cursor_col <= 7'd0;
                        end else if (char_in == CH_LF) begin
                            cursor_col <= 7'd0;
                            cursor_row <= row_next;
                            row_base   <= row_base_next;
                        end else if (char_in == CH_BS) begin
                            if (cursor_col != 7'd0) begin
                                cursor_col <= cursor_col - 7'd1;
                            end
                        end
                    end
                end
                CLEAR: begin
                    if (clr_cnt == CLR_TOTAL) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        cursor_col <= 7'd0;
                        cursor_row <= 5'd0;
                        row_base   <= '0;
                    end else begin
                        write_en <= 1'b1;
                        waddr    <= clr_cnt[ADDR_WIDTH-1:0];
                        wdata    <= SPACE;
                        clr_cnt  <= clr_cnt + (ADDR_WIDTH + 1)'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_ram_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_text_ram_writer
// Description : Scoreboard bench for text_ram_writer. Stimulus pushes the
//               expected RAM writes; a monitor pops them on each write_en.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_text_ram_writer;

    localparam int COLS = 80;
    localparam int ROWS = 30;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  char_in = 8'h00;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic        clear_req = 1'b0;
    logic [11:0] waddr;
    logic [7:0]  wdata;
    logic        write_en;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    text_ram_writer dut (
        .clk        (clk),
        .rst        (rst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .waddr      (waddr),
        .wdata      (wdata),
        .write_en   (write_en),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       addr;
        int       data;
    } wr_t;

    wr_t sb[$];
    int  tests = 0;
    int  fails = 0;
    int  mcol  = 0;
    int  mrow  = 0;
    int  ready_miss = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!rst && write_en) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr %0d data %0h, expected none", waddr, wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (int'(waddr) != e.addr || int'(wdata) != e.data) begin
                    fails++;
                    $display("FAIL write: got addr %0d data %0h, expected addr %0d data %0h",
                             waddr, wdata, e.addr, e.data);
                end
            end
        end
    end

    function automatic void model_newline();
        mcol = 0;
        mrow = (mrow == ROWS - 1) ? 0 : mrow + 1;
    endfunction

    // Called just after a negedge; returns just after the negedge following acceptance
    task automatic send(input logic [7:0] c);
        int n;
        char_in    = c;
        char_valid = 1'b1;
        #1;
        if (!char_ready) ready_miss++;
        n = 0;
        while (!char_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!char_ready) begin
            check("send_timeout", 0, 1);
        end else begin
            if (c >= 8'h20 && c != 8'h7F) begin
                sb.push_back('{mrow * COLS + mcol, int'(c)});
                if (mcol == COLS - 1) model_newline();
                else mcol++;
            end else if (c == 8'h0D) begin
                mcol = 0;
            end else if (c == 8'h0A) begin
                model_newline();
            end else if (c == 8'h08) begin
                if (mcol > 0) mcol--;
            end
            @(posedge clk);
        end
        @(negedge clk);
        char_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk); n++;
        end
        @(negedge clk);
        check(name, sb.size(), 0);
    endtask

    initial begin
        int n;
        // Reset state
        #1;
        check("rst_write_en", int'(write_en), 0);
        check("rst_waddr", int'(waddr), 0);
        check("rst_wdata", int'(wdata), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_col", int'(cursor_col), 0);
        check("rst_row", int'(cursor_row), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: single glyph at (0,0)
        send(8'h41);
        check("t1_col", int'(cursor_col), 1);
        drain("t1_drain");

        // BS back to col 0, then 2: 81 back-to-back glyphs
        send(8'h08);
        check("bs_col", int'(cursor_col), 0);
        ready_miss = 0;
        for (int i = 0; i < 81; i++) send(8'(8'h41 + (i % 26)));
        check("t2_ready", ready_miss, 0);
        check("t2_col", int'(cursor_col), 1);
        check("t2_row", int'(cursor_row), 1);
        drain("t2_drain");

        // 3: reach (5,2), then CR, LF, BS at column 0
        send(8'h0D);
        send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h30);
        check("t3_col5", int'(cursor_col), 5);
        check("t3_row2", int'(cursor_row), 2);
        send(8'h0D);
        check("t3_cr_col", int'(cursor_col), 0);
        send(8'h0A);
        check("t3_lf_col", int'(cursor_col), 0);
        check("t3_lf_row", int'(cursor_row), 3);
        send(8'h08);
        check("t3_bs_col", int'(cursor_col), 0);
        check("t3_bs_row", int'(cursor_row), 3);
        send(8'h01);
        drain("t3_drain");

        // 4: last cell (79,29) then wrap
        for (int i = 0; i < 26; i++) send(8'h0A);
        for (int i = 0; i < 79; i++) send(8'h62);
        check("t4_col79", int'(cursor_col), 79);
        check("t4_row29", int'(cursor_row), 29);
        send(8'h5A);
        check("t4_wrap_col", int'(cursor_col), 0);
        check("t4_wrap_row", int'(cursor_row), 0);
        drain("t4_drain");

        // 5: clear colliding with a held character
        char_in    = 8'h51;
        char_valid = 1'b1;
        clear_req  = 1'b1;
        #1;
        check("t5_ready_low", int'(char_ready), 0);
        for (int i = 0; i < COLS * ROWS; i++) sb.push_back('{i, 32'h20});
        sb.push_back('{0, 32'h51});
        @(posedge clk);
        @(negedge clk);
        clear_req = 1'b0;
        #1;
        n = 0;
        while (busy && n < 3000) begin
            if (char_ready) ready_miss++;
            n++;
            @(negedge clk); #1;
        end
        check("t5_busy_cycles", n, COLS * ROWS);
        check("t5_exit_col", int'(cursor_col), 0);
        check("t5_exit_row", int'(cursor_row), 0);
        check("t5_exit_ready", int'(char_ready), 1);
        @(posedge clk);
        @(negedge clk);
        char_valid = 1'b0;
        mcol = 1; mrow = 0;
        check("t5_q_col", int'(cursor_col), 1);
        drain("t5_drain");

        // 6: asynchronous reset after 100 clear writes
        clear_req = 1'b1;
        for (int i = 0; i < 100; i++) sb.push_back('{i, 32'h20});
        @(posedge clk);
        @(negedge clk);
        clear_req = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            #1; if (sb.size() == 0) break;
            @(negedge clk); n++;
        end
        #1;
        check("t6_count", sb.size(), 0);
        rst = 1'b1;
        #1;
        check("t6_rst_we", int'(write_en), 0);
        check("t6_rst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_ready", int'(char_ready), 1);
        check("t6_col", int'(cursor_col), 0);
        check("t6_row", int'(cursor_row), 0);
        repeat (3) @(negedge clk);
        check("t6_no_writes", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
